branch_resolve: RTL and testbench

//  Consumes the isNotEqual/isLessThan flags of comp_32 in the execute stage. Decides branch/jump

---
 rtl/branch_pkg.sv | 24 ++
 rtl/branch_resolve_if.sv | 36 +++
 rtl/branch_target_calc.sv | 40 ++++
 rtl/branch_resolve.sv | 115 +++++++++++
 tb/tb_branch_resolve.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types for the execute-stage branch resolver: branch kinds, FSM states
// and the widths of the immediate/jump fields that get extended to a PC.
package branch_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BNE  = 3'd1,
      BR_BLT  = 3'd2,
      BR_J    = 3'd3,
      BR_JAL  = 3'd4,
      BR_JR   = 3'd5,
      BR_BEX  = 3'd6
   } br_kind_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WAIT_ACK = 2'd1,
      ST_FLUSH    = 2'd2
   } state_t;

   localparam int IMM_W = 17;
   localparam int TGT_W = 27;

endpackage

// File: rtl/branch_resolve_if.sv
// Execute-stage input, fetch redirect handshake and link write-back bundle.
// master = surrounding pipeline, slave = branch_resolve.
interface branch_resolve_if #(
   parameter int PC_W = 32
) ();
   import branch_pkg::*;

   logic                   valid_in;
   logic                   ready_out;
   br_kind_t               br_kind;
   logic [PC_W-1:0]        pc_in;
   logic [IMM_W-1:0]       imm17;
   logic [TGT_W-1:0]       target27;
   logic [PC_W-1:0]        reg_target;
   logic                   isNotEqual;
   logic                   isLessThan;
   logic                   redirect_valid;
   logic [PC_W-1:0]        redirect_pc;
   logic                   redirect_ready;
   logic                   squash;
   logic                   link_valid;
   logic [PC_W-1:0]        link_pc;

   modport master (
      output valid_in, br_kind, pc_in, imm17, target27, reg_target,
             isNotEqual, isLessThan, redirect_ready,
      input  ready_out, redirect_valid, redirect_pc, squash, link_valid, link_pc
   );

   modport slave (
      input  valid_in, br_kind, pc_in, imm17, target27, reg_target,
             isNotEqual, isLessThan, redirect_ready,
      output ready_out, redirect_valid, redirect_pc, squash, link_valid, link_pc
   );

endinterface

// File: rtl/branch_target_calc.sv
// Pure combinational branch decision: taken flag and target PC from the
// instruction kind, its PC, offset/jump fields and the comparator flags.
module branch_target_calc
   import branch_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  br_kind_t          i_kind,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [IMM_W-1:0]  i_imm17,
   input  logic [TGT_W-1:0]  i_target27,
   input  logic [PC_W-1:0]   i_reg_target,
   input  logic              i_neq,
   input  logic              i_lt,
   output logic              o_taken,
   output logic [PC_W-1:0]   o_target
);

   logic [PC_W-1:0] w_rel_target;
   logic [PC_W-1:0] w_abs_target;

   // Relative targets wrap modulo 2^PC_W by construction of the adder width.
   assign w_rel_target = i_pc + PC_W'(1) + {{(PC_W-IMM_W){i_imm17[IMM_W-1]}}, i_imm17};
   assign w_abs_target = {{(PC_W-TGT_W){1'b0}}, i_target27};

   always_comb begin
      o_taken  = 1'b0;
      o_target = w_abs_target;
      case (i_kind)
         BR_BNE: begin o_taken = i_neq; o_target = w_rel_target; end
         BR_BLT: begin o_taken = i_lt;  o_target = w_rel_target; end
         BR_BEX: begin o_taken = i_neq; o_target = w_abs_target; end
         BR_J,
         BR_JAL: begin o_taken = 1'b1;  o_target = w_abs_target; end
         BR_JR:  begin o_taken = 1'b1;  o_target = i_reg_target; end
         default: begin o_taken = 1'b0; o_target = w_abs_target; end
      endcase
   end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolver: issues a registered fetch redirect, waits for
// its acknowledgement, then squashes FLUSH_CYCLES wrong-path slots.
//
//  state       | meaning
//  ST_IDLE     | accepting instructions, no redirect outstanding
//  ST_WAIT_ACK | redirect_valid high, holding redirect_pc until fetch accepts
//  ST_FLUSH    | killing wrong-path slots, r_cnt counts down to 0
module branch_resolve
   import branch_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int PC_W         = 32
) (
   input  logic           clock,
   input  logic           resetn,
   branch_resolve_if.slave bus
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [PC_W-1:0]   r_redirect_pc;
   logic              r_link_valid;
   logic [PC_W-1:0]   r_link_pc;

   logic              w_taken;
   logic [PC_W-1:0]   w_target;
   logic              w_ready;
   logic              w_squash;
   logic              w_redirect_valid;
   logic              w_accept;
   logic              w_is_jal;

   branch_target_calc #(.PC_W(PC_W)) u_calc (
      .i_kind       (bus.br_kind),
      .i_pc         (bus.pc_in),
      .i_imm17      (bus.imm17),
      .i_target27   (bus.target27),
      .i_reg_target (bus.reg_target),
      .i_neq        (bus.isNotEqual),
      .i_lt         (bus.isLessThan),
      .o_taken      (w_taken),
      .o_target     (w_target)
   );

   assign w_accept = bus.valid_in && w_ready && !w_squash;
   assign w_is_jal = (bus.br_kind == BR_JAL);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_redirect_pc <= '0;
         r_link_valid  <= 1'b0;
         r_link_pc     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_link_valid <= w_accept && w_is_jal;
         if (w_accept && w_taken) begin
            r_redirect_pc <= w_target;
         end
         if (w_accept && w_is_jal) begin
            r_link_pc <= bus.pc_in + PC_W'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && w_taken) begin
               w_state_nxt = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK: begin
            if (bus.redirect_ready) begin
               w_state_nxt = ST_FLUSH;
               w_cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
            end
         end
         ST_FLUSH: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the state register, so they change only on clock edges.
   always_comb begin
      w_ready          = (r_state != ST_WAIT_ACK);
      w_squash         = (r_state == ST_FLUSH);
      w_redirect_valid = (r_state == ST_WAIT_ACK);
   end

   assign bus.ready_out      = w_ready;
   assign bus.squash         = w_squash;
   assign bus.redirect_valid = w_redirect_valid;
   assign bus.redirect_pc    = r_redirect_pc;
   assign bus.link_valid     = r_link_valid;
   assign bus.link_pc        = r_link_pc;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed per step.
module tb_branch_resolve;
   import branch_pkg::*;

   logic clk;
   logic resetn;
   int   checks;
   int   failures;

   branch_resolve_if #(.PC_W(32)) bus ();

   branch_resolve #(.FLUSH_CYCLES(2), .PC_W(32)) dut (
      .clock  (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input br_kind_t k, input logic [31:0] pc,
                        input logic [16:0] imm, input logic [26:0] t27,
                        input logic [31:0] rt, input logic neq, input logic lt);
      bus.valid_in   = v;
      bus.br_kind    = k;
      bus.pc_in      = pc;
      bus.imm17      = imm;
      bus.target27   = t27;
      bus.reg_target = rt;
      bus.isNotEqual = neq;
      bus.isLessThan = lt;
   endtask

   task automatic idle_in();
      drive(1'b0, BR_NONE, 32'h0, 17'h0, 27'h0, 32'h0, 1'b0, 1'b0);
   endtask

   // Acknowledge the pending redirect and walk through both flush slots.
   task automatic ack_and_flush(input string tag);
      idle_in();
      bus.redirect_ready = 1'b1;
      step();
      chk({tag, "_flush0_squash"}, {31'b0, bus.squash}, 32'd1);
      chk({tag, "_flush0_rv"}, {31'b0, bus.redirect_valid}, 32'd0);
      bus.redirect_ready = 1'b0;
      step();
      chk({tag, "_flush1_squash"}, {31'b0, bus.squash}, 32'd1);
      step();
      chk({tag, "_idle_squash"}, {31'b0, bus.squash}, 32'd0);
      chk({tag, "_idle_ready"}, {31'b0, bus.ready_out}, 32'd1);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      resetn   = 1'b0;
      bus.redirect_ready = 1'b0;
      idle_in();
      step();
      step();
      resetn = 1'b1;
      step();
      chk("rst_rv", {31'b0, bus.redirect_valid}, 32'd0);
      chk("rst_rpc", bus.redirect_pc, 32'd0);
      chk("rst_squash", {31'b0, bus.squash}, 32'd0);
      chk("rst_link_valid", {31'b0, bus.link_valid}, 32'd0);
      chk("rst_ready", {31'b0, bus.ready_out}, 32'd1);

      // 1: BNE taken with fetch ready immediately
      drive(1'b1, BR_BNE, 32'd100, 17'd5, 27'h0, 32'h0, 1'b1, 1'b0);
      bus.redirect_ready = 1'b1;
      step();
      chk("t1_rv", {31'b0, bus.redirect_valid}, 32'd1);
      chk("t1_rpc", bus.redirect_pc, 32'd106);
      chk("t1_ready", {31'b0, bus.ready_out}, 32'd0);
      chk("t1_link_valid", {31'b0, bus.link_valid}, 32'd0);
      ack_and_flush("t1");

      // 2: BLT not taken, then next instruction accepted the following cycle
      drive(1'b1, BR_BLT, 32'd40, 17'd3, 27'h0, 32'h0, 1'b1, 1'b0);
      step();
      chk("t2_rv", {31'b0, bus.redirect_valid}, 32'd0);
      chk("t2_squash", {31'b0, bus.squash}, 32'd0);
      chk("t2_ready", {31'b0, bus.ready_out}, 32'd1);
      drive(1'b1, BR_BNE, 32'd200, 17'd1, 27'h0, 32'h0, 1'b1, 1'b0);
      step();
      chk("t2_next_rv", {31'b0, bus.redirect_valid}, 32'd1);
      chk("t2_next_rpc", bus.redirect_pc, 32'd202);
      ack_and_flush("t2");

      // NONE and BNE-with-neq=0 never redirect
      drive(1'b1, BR_NONE, 32'd9, 17'd1, 27'h123, 32'h0, 1'b1, 1'b1);
      step();
      chk("none_rv", {31'b0, bus.redirect_valid}, 32'd0);
      drive(1'b1, BR_BNE, 32'd9, 17'd1, 27'h0, 32'h0, 1'b0, 1'b1);
      step();
      chk("bne_nt_rv", {31'b0, bus.redirect_valid}, 32'd0);

      // 3: JAL with fetch stalling three cycles; a BNE waits upstream meanwhile
      drive(1'b1, BR_JAL, 32'd7, 17'd0, 27'h200, 32'h0, 1'b0, 1'b0);
      step();
      chk("t3_link_valid", {31'b0, bus.link_valid}, 32'd1);
      chk("t3_link_pc", bus.link_pc, 32'd8);
      chk("t3_rv0", {31'b0, bus.redirect_valid}, 32'd1);
      chk("t3_rpc0", bus.redirect_pc, 32'h200);
      chk("t3_ready0", {31'b0, bus.ready_out}, 32'd0);
      drive(1'b1, BR_BNE, 32'd500, 17'd2, 27'h0, 32'h0, 1'b1, 1'b0);
      step();
      chk("t3_link_pulse_end", {31'b0, bus.link_valid}, 32'd0);
      chk("t3_ready1", {31'b0, bus.ready_out}, 32'd0);
      chk("t3_rpc1", bus.redirect_pc, 32'h200);
      step();
      chk("t3_ready2", {31'b0, bus.ready_out}, 32'd0);
      chk("t3_rpc2", bus.redirect_pc, 32'h200);
      chk("t3_rv2", {31'b0, bus.redirect_valid}, 32'd1);
      ack_and_flush("t3");

      // 4: target wrap cases
      drive(1'b1, BR_BLT, 32'd10, 17'h1FFF5, 27'h0, 32'h0, 1'b0, 1'b1);
      step();
      chk("t4_blt_rv", {31'b0, bus.redirect_valid}, 32'd1);
      chk("t4_blt_rpc", bus.redirect_pc, 32'd0);
      ack_and_flush("t4a");
      drive(1'b1, BR_BNE, 32'h7FFF_FFFF, 17'h10000, 27'h0, 32'h0, 1'b1, 1'b0);
      step();
      chk("t4_neg_rpc", bus.redirect_pc, 32'h7FFF_0000);
      ack_and_flush("t4b");
      drive(1'b1, BR_BNE, 32'hFFFF_FFFF, 17'd0, 27'h0, 32'h0, 1'b1, 1'b0);
      step();
      chk("t4_wrap_rv", {31'b0, bus.redirect_valid}, 32'd1);
      chk("t4_wrap_rpc", bus.redirect_pc, 32'd0);
      ack_and_flush("t4c");

      // 5: reset while a JR redirect waits for acknowledgement
      drive(1'b1, BR_JR, 32'd50, 17'd0, 27'h0, 32'h1234, 1'b0, 1'b0);
      step();
      chk("t5_rv", {31'b0, bus.redirect_valid}, 32'd1);
      chk("t5_rpc", bus.redirect_pc, 32'h1234);
      idle_in();
      resetn = 1'b0;
      step();
      chk("t5_rst_rv", {31'b0, bus.redirect_valid}, 32'd0);
      chk("t5_rst_rpc", bus.redirect_pc, 32'd0);
      chk("t5_rst_squash", {31'b0, bus.squash}, 32'd0);
      chk("t5_rst_link_pc", bus.link_pc, 32'd0);
      chk("t5_rst_ready", {31'b0, bus.ready_out}, 32'd1);
      resetn = 1'b1;
      bus.redirect_ready = 1'b1;
      step();
      chk("t5_post_squash0", {31'b0, bus.squash}, 32'd0);
      chk("t5_post_rv0", {31'b0, bus.redirect_valid}, 32'd0);
      step();
      chk("t5_post_squash1", {31'b0, bus.squash}, 32'd0);
      bus.redirect_ready = 1'b0;

      // 6: BEX not taken, then taken; instruction during FLUSH is discarded
      drive(1'b1, BR_BEX, 32'd60, 17'd0, 27'h50, 32'h0, 1'b0, 1'b1);
      step();
      chk("t6_nt_rv", {31'b0, bus.redirect_valid}, 32'd0);
      drive(1'b1, BR_BEX, 32'd61, 17'd0, 27'h50, 32'h0, 1'b1, 1'b0);
      step();
      chk("t6_rv", {31'b0, bus.redirect_valid}, 32'd1);
      chk("t6_rpc", bus.redirect_pc, 32'h50);
      idle_in();
      bus.redirect_ready = 1'b1;
      step();
      chk("t6_flush0", {31'b0, bus.squash}, 32'd1);
      bus.redirect_ready = 1'b0;
      drive(1'b1, BR_BNE, 32'd300, 17'd2, 27'h0, 32'h0, 1'b1, 1'b0);
      step();
      chk("t6_flush1", {31'b0, bus.squash}, 32'd1);
      chk("t6_flush1_rv", {31'b0, bus.redirect_valid}, 32'd0);
      chk("t6_flush1_ready", {31'b0, bus.ready_out}, 32'd1);
      drive(1'b1, BR_J, 32'd400, 17'd0, 27'h77, 32'h0, 1'b0, 1'b0);
      step();
      chk("t6_discard_rv", {31'b0, bus.redirect_valid}, 32'd0);
      chk("t6_discard_rpc", bus.redirect_pc, 32'h50);
      chk("t6_idle_squash", {31'b0, bus.squash}, 32'd0);
      step();
      chk("t6_after_flush_rv", {31'b0, bus.redirect_valid}, 32'd1);
      chk("t6_after_flush_rpc", bus.redirect_pc, 32'h77);
      ack_and_flush("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
